// File: rtl/wb_stage.sv
// wb_stage: register-file writeback stage.
// Accepts one instruction per cycle from MEM. ALU results are written the
// cycle after transfer. Loads wait for dmem_rvalid, then the selected byte or
// half-word is extracted and sign- or zero-extended before the write.
// Misaligned loads and load timeouts set the sticky load_err and produce no write.
// Optional feature: define WB_RETIRE_CNT_EN to add the retire_cnt port and
// counter. With the macro undefined, the port and the counter do not exist.
module wb_stage #(
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic        m_reg_write,
    input  logic        m_mem_to_reg,
    input  logic [2:0]  m_load_type,
    input  logic [1:0]  m_addr_lo,
    input  logic [31:0] m_alu_result,
    input  logic [4:0]  m_write_reg,
    input  logic        flush,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_reg_write,
    output logic [4:0]  wb_write_reg,
    output logic [31:0] wb_write_data,
    output logic        load_err
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0] retire_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_LD, WRITE} state_t;

    // The last WAIT_LD cycle that is allowed to pass without dmem_rvalid.
    localparam logic [7:0] TO_LAST = 8'(LOAD_TIMEOUT - 1);

    state_t      state;
    logic        cap_rw;
    logic [2:0]  cap_lt;
    logic [1:0]  cap_alo;
    logic [4:0]  cap_wr;
    logic [7:0]  ld_cnt;
    logic        xfer;
    logic        misalign;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // m_ready depends only on the state, so it reads 1 while reset holds the state in IDLE.
    assign m_ready = (state != WAIT_LD);
    assign xfer    = m_valid & m_ready & ~flush;

    // Select the lane of the returned word and extend it according to the load type.
    always_comb begin
        ld_byte  = dmem_rdata[7:0];
        ld_half  = cap_alo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        ld_data  = dmem_rdata;
        misalign = (cap_alo != 2'b00);
        case (cap_alo)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        case (cap_lt)
            3'b001: begin ld_data = {{24{ld_byte[7]}}, ld_byte};  misalign = 1'b0;       end
            3'b010: begin ld_data = {24'h0, ld_byte};             misalign = 1'b0;       end
            3'b011: begin ld_data = {{16{ld_half[15]}}, ld_half}; misalign = cap_alo[0]; end
            3'b100: begin ld_data = {16'h0, ld_half};             misalign = cap_alo[0]; end
            default: ;
        endcase
    end

    // Main FSM. Writeback outputs are set on the same edge that enters WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wb_reg_write  <= 1'b0;
            wb_write_reg  <= 5'd0;
            wb_write_data <= 32'd0;
            load_err      <= 1'b0;
            ld_cnt        <= 8'd0;
            cap_rw        <= 1'b0;
            cap_lt        <= 3'd0;
            cap_alo       <= 2'd0;
            cap_wr        <= 5'd0;
        end else begin
            wb_reg_write <= 1'b0;
            case (state)
                IDLE, WRITE: begin
                    if (xfer) begin
                        cap_rw  <= m_reg_write;
                        cap_lt  <= m_load_type;
                        cap_alo <= m_addr_lo;
                        cap_wr  <= m_write_reg;
                        if (m_mem_to_reg) begin
                            state  <= WAIT_LD;
                            ld_cnt <= 8'd0;
                        end else begin
                            state         <= WRITE;
                            wb_reg_write  <= m_reg_write & (m_write_reg != 5'd0);
                            wb_write_reg  <= m_write_reg;
                            wb_write_data <= m_alu_result;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_LD: begin
                    if (flush) begin
                        // The load is abandoned. Data returned in the same cycle is dropped.
                        state  <= IDLE;
                        ld_cnt <= 8'd0;
                    end else if (dmem_rvalid) begin
                        ld_cnt <= 8'd0;
                        if (misalign) begin
                            load_err <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            state         <= WRITE;
                            wb_reg_write  <= cap_rw & (cap_wr != 5'd0);
                            wb_write_reg  <= cap_wr;
                            wb_write_data <= ld_data;
                        end
                    end else if (ld_cnt == TO_LAST) begin
                        load_err <= 1'b1;
                        ld_cnt   <= 8'd0;
                        state    <= IDLE;
                    end else begin
                        ld_cnt <= ld_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Count every WRITE cycle, including those with reg_write low. The counter wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retire_cnt <= 32'd0;
        else if (state == WRITE)
            retire_cnt <= retire_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage. Expected writes are queued when stimulus
// is driven. A negedge monitor pops the queue and compares each write pulse.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_ready;
    logic        m_reg_write = 1'b0;
    logic        m_mem_to_reg = 1'b0;
    logic [2:0]  m_load_type = 3'd0;
    logic [1:0]  m_addr_lo = 2'd0;
    logic [31:0] m_alu_result = 32'd0;
    logic [4:0]  m_write_reg = 5'd0;
    logic        flush = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        load_err;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    logic [36:0] sb[$];
    int wr_cyc[$];

    wb_stage #(.LOAD_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_reg_write(m_reg_write), .m_mem_to_reg(m_mem_to_reg),
        .m_load_type(m_load_type), .m_addr_lo(m_addr_lo),
        .m_alu_result(m_alu_result), .m_write_reg(m_write_reg),
        .flush(flush), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .load_err(load_err)
`ifdef WB_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Writeback monitor.
    always @(negedge clk) begin
        if (rst_n && wb_reg_write) begin
            wr_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_wr", {27'd0, wb_write_reg}, 32'd0);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                chk("wr_reg", {27'd0, wb_write_reg}, {27'd0, e[36:32]});
                chk("wr_data", wb_write_data, e[31:0]);
            end
        end
    end

    // Call this at posedge+1. It returns at posedge+1, one cycle after the transfer.
    task automatic issue(input logic rw, input logic m2r, input logic [2:0] lt,
                         input logic [1:0] alo, input logic [31:0] alu, input logic [4:0] wr);
        chk("xfer_rdy", {31'd0, m_ready}, 32'd1);
        m_valid = 1'b1; m_reg_write = rw; m_mem_to_reg = m2r; m_load_type = lt;
        m_addr_lo = alo; m_alu_result = alu; m_write_reg = wr;
        @(posedge clk); #1;
        m_valid = 1'b0;
    endtask

    task automatic alu_op(input logic [4:0] wr, input logic [31:0] d);
        if (wr != 5'd0) sb.push_back({wr, d});
        issue(1'b1, 1'b0, 3'd0, 2'd0, d, wr);
    endtask

    // The load returns rvalid in WAIT_LD cycle dly.
    task automatic ld(input logic [2:0] lt, input logic [1:0] alo, input logic [4:0] wr,
                      input logic [31:0] rd, input int dly, input logic [31:0] exp_d, input logic bad);
        if (!bad && wr != 5'd0) sb.push_back({wr, exp_d});
        issue(1'b1, 1'b1, lt, alo, 32'hDEAD0000, wr);
        for (int i = 1; i < dly; i++) begin
            chk("ld_wait_rdy", {31'd0, m_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("ld_last_rdy", {31'd0, m_ready}, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = rd;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        if (bad) begin
            chk("misal_err", {31'd0, load_err}, 32'd1);
            chk("misal_nowr", {31'd0, wb_reg_write}, 32'd0);
            chk("misal_idle", {31'd0, m_ready}, 32'd1);
        end else begin
            chk("ld_pulse", {31'd0, wb_reg_write}, {31'd0, wr != 5'd0});
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ready", {31'd0, m_ready}, 32'd1);
        chk("rst_wr", {31'd0, wb_reg_write}, 32'd0);
        chk("rst_reg", {27'd0, wb_write_reg}, 32'd0);
        chk("rst_data", wb_write_data, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
`ifdef WB_RETIRE_CNT_EN
        chk("rst_retire", retire_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", {31'd0, m_ready}, 32'd1);
    endtask

    initial begin
        int base;
        #2;
        do_reset();

        // ALU op: the write pulse comes one cycle after the transfer.
        alu_op(5'd5, 32'h12345678);
        chk("alu_lat", {31'd0, wb_reg_write}, 32'd1);
        @(posedge clk); #1;
        chk("alu_one_pulse", {31'd0, wb_reg_write}, 32'd0);

        // Load lanes and extension.
        ld(3'b001, 2'd2, 5'd7,  32'h00800000, 3, 32'hFFFFFF80, 1'b0);
        ld(3'b010, 2'd2, 5'd8,  32'h00800000, 3, 32'h00000080, 1'b0);
        ld(3'b011, 2'd2, 5'd9,  32'h80010000, 1, 32'hFFFF8001, 1'b0);
        ld(3'b100, 2'd2, 5'd10, 32'h80010000, 2, 32'h00008001, 1'b0);
        ld(3'b000, 2'd0, 5'd11, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b0);
        ld(3'b001, 2'd3, 5'd12, 32'h7F000000, 1, 32'h0000007F, 1'b0);
        ld(3'b111, 2'd0, 5'd13, 32'hCAFEF00D, 1, 32'hCAFEF00D, 1'b0);
        ld(3'b000, 2'd0, 5'd0,  32'h11111111, 1, 32'h0,       1'b0);
        chk("no_err_yet", {31'd0, load_err}, 32'd0);

        // A flush in IDLE blocks capture.
        m_valid = 1'b1; m_reg_write = 1'b1; m_mem_to_reg = 1'b0;
        m_write_reg = 5'd14; m_alu_result = 32'hBAD0BAD0; flush = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0; flush = 1'b0;
        chk("flush_idle_nowr", {31'd0, wb_reg_write}, 32'd0);

        // A write already in progress completes under flush, and nothing new is captured.
        alu_op(5'd15, 32'hA5A5A5A5);
        m_valid = 1'b1; m_write_reg = 5'd16; m_alu_result = 32'h0BAD0BAD; flush = 1'b1;
        @(posedge clk); #1;
        m_valid = 1'b0; flush = 1'b0;
        chk("flush_wr_nowr", {31'd0, wb_reg_write}, 32'd0);

        // Flush in WAIT_LD cycle 2, together with rvalid.
        issue(1'b1, 1'b1, 3'b000, 2'd0, 32'h0, 5'd17);
        @(posedge clk); #1;
        flush = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h99999999;
        @(posedge clk); #1;
        flush = 1'b0; dmem_rvalid = 1'b0;
        chk("flush_ld_idle", {31'd0, m_ready}, 32'd1);
        chk("flush_ld_err", {31'd0, load_err}, 32'd0);
        @(posedge clk); #1;
        chk("flush_ld_nowr", {31'd0, wb_reg_write}, 32'd0);

        // Timeout: load_err rises after exactly 15 WAIT_LD cycles.
        issue(1'b1, 1'b1, 3'b000, 2'd0, 32'h0, 5'd18);
        for (int i = 1; i < 15; i++) begin
            if (load_err !== 1'b0 || m_ready !== 1'b0) chk("to_early", {30'd0, load_err, m_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("to_cycle15_err", {31'd0, load_err}, 32'd0);
        @(posedge clk); #1;
        chk("to_err", {31'd0, load_err}, 32'd1);
        chk("to_idle", {31'd0, m_ready}, 32'd1);
        chk("to_nowr", {31'd0, wb_reg_write}, 32'd0);
        alu_op(5'd19, 32'h13579BDF);
        chk("err_sticky", {31'd0, load_err}, 32'd1);
        @(posedge clk); #1;

        // Misaligned loads.
        do_reset();
        ld(3'b011, 2'd1, 5'd20, 32'hFFFFFFFF, 1, 32'h0, 1'b1);
        do_reset();
        ld(3'b000, 2'd2, 5'd21, 32'hFFFFFFFF, 2, 32'h0, 1'b1);

        // Reset in the middle of WAIT_LD. Late data after release must not write.
        do_reset();
        issue(1'b1, 1'b1, 3'b000, 2'd0, 32'h0, 5'd22);
        @(posedge clk); #1;
        do_reset();
        dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk("rst_ld_nowr", {31'd0, wb_reg_write}, 32'd0);
        @(posedge clk); #1;

        // Four back-to-back ALU ops: the r0 op must not pulse.
        base = wr_cyc.size();
        alu_op(5'd0, 32'hA0);
        alu_op(5'd1, 32'hA1);
        alu_op(5'd2, 32'hA2);
        alu_op(5'd3, 32'hA3);
        @(posedge clk); #1;
        chk("b2b_count", wr_cyc.size() - base, 32'd3);
        if (wr_cyc.size() - base == 3) begin
            chk("b2b_gap1", wr_cyc[base+1] - wr_cyc[base], 32'd1);
            chk("b2b_gap2", wr_cyc[base+2] - wr_cyc[base+1], 32'd1);
        end
`ifdef WB_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, 32'd4);
`endif
        @(posedge clk); #1;
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
